out_pkt_monitor: RTL
====================

OUT_PKT_MONITOR -- requirements
Module: out_pkt_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream data width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, stream control width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low (reset==0 resets).
REQ-005 SHALL have port in_data  input  DATA_WIDTH  upstream word (user_datapath out_data).
REQ-006 SHALL have port in_ctrl  input  CTRL_WIDTH  upstream control (user_datapath out_ctrl).
REQ-007 SHALL have port in_wr  input  1  upstream write strobe.
REQ-008 SHALL have port in_rdy  output  1  block can accept a word this cycle.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  downstream word.
REQ-010 SHALL have port out_ctrl  output  CTRL_WIDTH  downstream control.
REQ-011 SHALL have port out_wr  output  1  downstream write strobe.
REQ-012 SHALL have port out_rdy  input  1  downstream can accept a word.
REQ-013 SHALL have port clr_stats  input  1  synchronous clear of all statistics.
REQ-014 SHALL have port pkt_count  output  32  completed packets.
REQ-015 SHALL have port word_count  output  32  accepted words.
REQ-016 SHALL have port err_count  output  16  framing/protocol errors.
REQ-017 SHALL have port max_pkt_words  output  16  longest completed packet, words incl. headers.

Function
REQ-018 Buffering SHALL be a 2-entry FIFO; word accepted when in_wr && in_rdy; in_rdy = (occupancy < 2), from registered state only.
REQ-019 out_wr SHALL equal (occupancy != 0) && out_rdy; out_data/out_ctrl SHALL present the head entry; head pops when out_wr.
REQ-020 Latency SHALL be exactly 1 cycle: word accepted at edge N is on out_data with out_wr possible in cycle after N; order preserved, data unmodified.
REQ-021 Simultaneous accept and pop with occupancy 2 is impossible (in_rdy low); with occupancy 1 SHALL leave occupancy 1.
REQ-022 in_wr while in_rdy low: word SHALL be discarded, err_count +1, framing state unchanged.
REQ-023 Framing FSM on accepted words, states IDLE, HDR, BODY; classes: H = ctrl==all-ones, D = ctrl==0, E = any other ctrl.
REQ-024 IDLE: H -> HDR (start packet, len=1); D -> IDLE, err +1; E -> IDLE, err +1.
REQ-025 HDR: H -> HDR, len+1; D -> BODY, len+1; E -> IDLE, err +1, packet abandoned.
REQ-026 BODY: D -> BODY, len+1; E -> IDLE, packet complete (len+1), pkt_count +1, max_pkt_words updated if larger; H -> HDR, err +1, old packet abandoned, new packet len=1.
REQ-027 Internal len SHALL saturate at 0xFFFF; max_pkt_words compares saturated value.
REQ-028 word_count SHALL +1 per accepted word; all counters SHALL saturate at all-ones, never wrap.
REQ-029 Multiple err sources in one cycle impossible; each counter increments at most 1 per cycle.
REQ-030 clr_stats SHALL zero pkt_count, word_count, err_count, max_pkt_words next edge, taking priority over same-cycle increments; FSM and FIFO unaffected.

Reset
REQ-031 reset==0 at an edge SHALL set FIFO empty, FSM IDLE, len 0, all counters 0; priority over all other inputs.
REQ-032 During and after reset: in_rdy=1 (occupancy 0), out_wr=0, out_data=0, out_ctrl=0.
REQ-033 Reset mid-packet SHALL discard buffered words without emitting them; next packet counted from IDLE.

Verification
REQ-034 Packet FF,00,00,00,0x0F with out_rdy=1 -> 5 words out, each 1 cycle later, unchanged; pkt_count=1, word_count=5, max_pkt_words=5, err_count=0.
REQ-035 out_rdy=0, write 3 words back-to-back -> first two accepted, in_rdy=0 after second, third discarded, err_count=1; out_rdy=1 -> exactly 2 words out in order.
REQ-036 Stray ctrl 0x01 in IDLE, then FF,00,FF,00,0x80 -> err_count=2, pkt_count=1, max_pkt_words=3.
REQ-037 word_count preloaded near 0xFFFFFFFF via traffic/force, further words -> holds 0xFFFFFFFF; clr_stats with in_wr same cycle -> all counters 0.
REQ-038 reset=0 asserted with 2 words buffered mid-packet -> out_wr=0, FIFO empty, counters 0; following full packet -> pkt_count=1, no errors.

Source files
------------

// File: rtl/out_pkt_monitor.sv
// Output-side packet monitor: 2-entry pass-through FIFO with
// framing checks and saturating traffic statistics.
module out_pkt_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  clr_stats,
  output logic [31:0]           pkt_count,
  output logic [31:0]           word_count,
  output logic [15:0]           err_count,
  output logic [15:0]           max_pkt_words
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY
  } state_t;

  logic [DATA_WIDTH-1:0] r_data [2];
  logic [CTRL_WIDTH-1:0] r_ctrl [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_occ;

  logic w_push;
  logic w_pop;
  logic w_drop;

  assign in_rdy   = (r_occ != 2'd2);
  assign out_wr   = (r_occ != 2'd0) && out_rdy;
  assign w_push   = in_wr && in_rdy;
  assign w_pop    = out_wr;
  assign w_drop   = in_wr && !in_rdy;
  assign out_data = (r_occ != 2'd0) ? r_data[r_rptr] : '0;
  assign out_ctrl = (r_occ != 2'd0) ? r_ctrl[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= in_data;
        r_ctrl[r_wptr] <= in_ctrl;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Word classes: all-ones ctrl is a header, zero ctrl is payload,
  // anything else marks the last word of a packet.
  logic w_is_h;
  logic w_is_d;
  logic w_is_e;

  assign w_is_h = &in_ctrl;
  assign w_is_d = (in_ctrl == '0);
  assign w_is_e = !w_is_h && !w_is_d;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_len;
  logic [15:0] w_len_nxt;
  logic [15:0] w_len_inc;
  logic        w_frm_err;
  logic        w_pkt_done;

  assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_frm_err   = 1'b0;
    w_pkt_done  = 1'b0;
    if (w_push) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_is_h: begin
              w_state_nxt = S_HDR;
              w_len_nxt   = 16'd1;
            end
            default: begin
              w_frm_err = 1'b1;
            end
          endcase
        end
        S_HDR: begin
          unique case (1'b1)
            w_is_h: begin
              w_len_nxt = w_len_inc;
            end
            w_is_d: begin
              w_state_nxt = S_BODY;
              w_len_nxt   = w_len_inc;
            end
            default: begin
              w_state_nxt = S_IDLE;
              w_len_nxt   = 16'd0;
              w_frm_err   = 1'b1;
            end
          endcase
        end
        S_BODY: begin
          unique case (1'b1)
            w_is_d: begin
              w_len_nxt = w_len_inc;
            end
            w_is_e: begin
              w_state_nxt = S_IDLE;
              w_len_nxt   = 16'd0;
              w_pkt_done  = 1'b1;
            end
            default: begin
              w_state_nxt = S_HDR;
              w_len_nxt   = 16'd1;
              w_frm_err   = 1'b1;
            end
          endcase
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_len_nxt   = 16'd0;
        end
      endcase
    end
  end

  logic [31:0] r_pkt_cnt;
  logic [31:0] r_word_cnt;
  logic [15:0] r_err_cnt;
  logic [15:0] r_max;
  logic        w_err_inc;

  // A dropped write can only occur when nothing is accepted,
  // so the two error sources never coincide.
  assign w_err_inc = w_frm_err || w_drop;

  always_ff @(posedge clk) begin
    if (!reset || clr_stats) begin
      r_pkt_cnt  <= 32'd0;
      r_word_cnt <= 32'd0;
      r_err_cnt  <= 16'd0;
      r_max      <= 16'd0;
    end else begin
      if (w_push && (r_word_cnt != 32'hFFFF_FFFF)) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_pkt_done && (r_pkt_cnt != 32'hFFFF_FFFF)) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_pkt_done && (w_len_inc > r_max)) begin
        r_max <= w_len_inc;
      end
    end
  end

  assign pkt_count     = r_pkt_cnt;
  assign word_count    = r_word_cnt;
  assign err_count     = r_err_cnt;
  assign max_pkt_words = r_max;

endmodule
